// File: rtl/matmul_systolic_nxn_if.sv
// Bus bundle for the N x N systolic matmul engine: job command, operand RAM ports, result row stream.
// Result stream handshake: a row moves on every rising edge where c_valid && c_ready; once raised, c_valid, c_row and c_data hold steady until that transfer.
interface matmul_systolic_nxn_if #(
    parameter int N      = 4,
    parameter int DWIDTH = 16,
    parameter int CWIDTH = 32,
    parameter int AWIDTH = 9,
    parameter int KWIDTH = 9
);
    localparam int RW = $clog2(N);

    logic                  start;
    logic [KWIDTH-1:0]     k_len;
    logic [AWIDTH-1:0]     a_base;
    logic [AWIDTH-1:0]     b_base;
    logic                  acc_en;
    logic [AWIDTH-1:0]     a_addr;
    logic [AWIDTH-1:0]     b_addr;
    logic [N*DWIDTH-1:0]   a_data;
    logic [N*DWIDTH-1:0]   b_data;
    logic                  c_valid;
    logic                  c_ready;
    logic [RW-1:0]         c_row;
    logic [N*CWIDTH-1:0]   c_data;
    logic                  busy;
    logic                  done;
    logic                  ovf;

    modport master (
        output start, k_len, a_base, b_base, acc_en, a_data, b_data, c_ready,
        input  a_addr, b_addr, c_valid, c_row, c_data, busy, done, ovf
    );

    modport slave (
        input  start, k_len, a_base, b_base, acc_en, a_data, b_data, c_ready,
        output a_addr, b_addr, c_valid, c_row, c_data, busy, done, ovf
    );
endinterface

// File: rtl/matmul_systolic_nxn.sv
// N x N output-stationary systolic matmul engine: C = A*B (optionally accumulated), drained row by row.
// Define MATMUL_SATURATE_EN to clamp accumulators at all-ones instead of wrapping.
module matmul_systolic_nxn #(
    parameter int N      = 4,
    parameter int DWIDTH = 16,
    parameter int CWIDTH = 32,
    parameter int AWIDTH = 9,
    parameter int KWIDTH = 9
) (
    input logic                    clk,
    input logic                    reset,
    matmul_systolic_nxn_if.slave   bus
);
    localparam int RW   = $clog2(N);
    localparam int CNTW = (KWIDTH > 6) ? KWIDTH : 6;
    localparam logic [CNTW-1:0] FLUSH_LAST = CNTW'(2 * N - 1);

    typedef enum logic [2:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [KWIDTH-1:0]   k_q, k_d;
    logic [AWIDTH-1:0]   a_addr_q, a_addr_d, b_addr_q, b_addr_d;
    logic                c_valid_q, c_valid_d;
    logic [RW-1:0]       c_row_q, c_row_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                feed_vld_q, feed_vld_d;
    logic                ovf_q, ovf_d;
    logic                acc_clr;
    logic [N*N-1:0]      ovf_hit;

    logic [DWIDTH-1:0]   a_lane [N];
    logic [DWIDTH-1:0]   b_lane [N];
    logic [DWIDTH-1:0]   sk_a [N];
    logic [DWIDTH-1:0]   sk_b [N];
    logic                sk_v [N];
    logic [DWIDTH-1:0]   pe_a [N][N];
    logic [DWIDTH-1:0]   pe_b [N][N];
    logic                pe_v [N][N];
    logic [CWIDTH-1:0]   acc_w [N][N];
    logic [N*CWIDTH-1:0] c_data_w;

    assign acc_clr = (state_q == S_IDLE) && bus.start && !bus.acc_en;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        a_addr_d   = a_addr_q;
        b_addr_d   = b_addr_q;
        c_valid_d  = c_valid_q;
        c_row_d    = c_row_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        feed_vld_d = (state_q == S_FEED);
        ovf_d      = acc_clr ? 1'b0 : (ovf_q | (|ovf_hit));
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    k_d    = bus.k_len;
                    busy_d = 1'b1;
                    cnt_d  = '0;
                    if (bus.k_len == '0) begin
                        state_d = S_FLUSH;
                    end else begin
                        state_d  = S_FEED;
                        a_addr_d = bus.a_base;
                        b_addr_d = bus.b_base;
                    end
                end
            end
            S_FEED: begin
                if ((cnt_q + CNTW'(1)) == CNTW'(k_q)) begin
                    state_d = S_FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d    = cnt_q + CNTW'(1);
                    a_addr_d = a_addr_q + AWIDTH'(1);
                    b_addr_d = b_addr_q + AWIDTH'(1);
                end
            end
            // Flush runs until the skewed wavefront has fully left PE(N-1,N-1).
            S_FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    state_d   = S_DRAIN;
                    cnt_d     = '0;
                    c_valid_d = 1'b1;
                    c_row_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            S_DRAIN: begin
                if (c_valid_q && bus.c_ready) begin
                    if (c_row_q == RW'(N - 1)) begin
                        state_d   = S_DONE;
                        c_valid_d = 1'b0;
                        c_row_d   = '0;
                        done_d    = 1'b1;
                    end else begin
                        c_row_d = c_row_q + RW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            k_q        <= '0;
            a_addr_q   <= '0;
            b_addr_q   <= '0;
            c_valid_q  <= 1'b0;
            c_row_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            feed_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            a_addr_q   <= a_addr_d;
            b_addr_q   <= b_addr_d;
            c_valid_q  <= c_valid_d;
            c_row_q    <= c_row_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            feed_vld_q <= feed_vld_d;
            ovf_q      <= ovf_d;
        end
    end

    // Lane i of both operands is delayed i cycles so A row r and B column c meet at PE(r,c).
    for (genvar i = 0; i < N; i++) begin : g_lane
        assign a_lane[i] = bus.a_data[i*DWIDTH +: DWIDTH];
        assign b_lane[i] = bus.b_data[i*DWIDTH +: DWIDTH];
        if (i == 0) begin : g_sk
            assign sk_a[i] = a_lane[i];
            assign sk_b[i] = b_lane[i];
            assign sk_v[i] = feed_vld_q;
        end else begin : g_sk
            logic [DWIDTH-1:0] ska_q [i];
            logic [DWIDTH-1:0] ska_d [i];
            logic [DWIDTH-1:0] skb_q [i];
            logic [DWIDTH-1:0] skb_d [i];
            logic              skv_q [i];
            logic              skv_d [i];
            always_comb begin
                ska_d[0] = a_lane[i];
                skb_d[0] = b_lane[i];
                skv_d[0] = feed_vld_q;
                for (int s = 1; s < i; s++) begin
                    ska_d[s] = ska_q[s-1];
                    skb_d[s] = skb_q[s-1];
                    skv_d[s] = skv_q[s-1];
                end
            end
            always_ff @(posedge clk) begin
                for (int s = 0; s < i; s++) begin
                    if (reset) begin
                        ska_q[s] <= '0;
                        skb_q[s] <= '0;
                        skv_q[s] <= 1'b0;
                    end else begin
                        ska_q[s] <= ska_d[s];
                        skb_q[s] <= skb_d[s];
                        skv_q[s] <= skv_d[s];
                    end
                end
            end
            assign sk_a[i] = ska_q[i-1];
            assign sk_b[i] = skb_q[i-1];
            assign sk_v[i] = skv_q[i-1];
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            logic [DWIDTH-1:0]   a_in, b_in, pa_q, pa_d, pb_q, pb_d;
            logic                v_in, pv_q, pv_d, hit;
            logic [2*DWIDTH-1:0] prod;
            logic [CWIDTH:0]     sum;
            logic [CWIDTH-1:0]   acc_q, acc_d;

            if (c == 0) begin : g_w
                assign a_in = sk_a[r];
                assign v_in = sk_v[r];
            end else begin : g_w
                assign a_in = pe_a[r][c-1];
                assign v_in = pe_v[r][c-1];
            end
            if (r == 0) begin : g_n
                assign b_in = sk_b[c];
            end else begin : g_n
                assign b_in = pe_b[r-1][c];
            end

            assign prod = {{DWIDTH{1'b0}}, a_in} * {{DWIDTH{1'b0}}, b_in};
            assign sum  = {1'b0, acc_q} + {{(CWIDTH + 1 - 2*DWIDTH){1'b0}}, prod};

            always_comb begin
                pa_d  = a_in;
                pb_d  = b_in;
                pv_d  = v_in;
                hit   = 1'b0;
                acc_d = acc_q;
                if (acc_clr) begin
                    acc_d = '0;
                end else if (v_in) begin
                    hit = sum[CWIDTH];
`ifdef MATMUL_SATURATE_EN
                    acc_d = sum[CWIDTH] ? {CWIDTH{1'b1}} : sum[CWIDTH-1:0];
`else
                    acc_d = sum[CWIDTH-1:0];
`endif
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    pa_q  <= '0;
                    pb_q  <= '0;
                    pv_q  <= 1'b0;
                    acc_q <= '0;
                end else begin
                    pa_q  <= pa_d;
                    pb_q  <= pb_d;
                    pv_q  <= pv_d;
                    acc_q <= acc_d;
                end
            end

            assign pe_a[r][c]       = pa_q;
            assign pe_b[r][c]       = pb_q;
            assign pe_v[r][c]       = pv_q;
            assign acc_w[r][c]      = acc_q;
            assign ovf_hit[r*N + c] = hit;
        end
    end

    always_comb begin
        c_data_w = '0;
        for (int j = 0; j < N; j++) begin
            c_data_w[j*CWIDTH +: CWIDTH] = acc_w[c_row_q][j];
        end
    end

    assign bus.a_addr  = a_addr_q;
    assign bus.b_addr  = b_addr_q;
    assign bus.c_valid = c_valid_q;
    assign bus.c_row   = c_row_q;
    assign bus.c_data  = c_data_w;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_matmul_systolic_nxn.sv
// Directed bench for matmul_systolic_nxn: job table plus backpressure, busy-start and mid-job reset sequences.
module tb_matmul_systolic_nxn;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int CW = 32;
  localparam int AW = 9;
  localparam int KW = 9;
  localparam int RW = $clog2(N);

`ifdef MATMUL_SATURATE_EN
  localparam logic [CW-1:0] OVF_K3     = 32'hFFFF_FFFF;
  localparam logic [CW-1:0] OVF_K3_ACC = 32'hFFFF_FFFF;
`else
  localparam logic [CW-1:0] OVF_K3     = 32'hFFFA_0003;
  localparam logic [CW-1:0] OVF_K3_ACC = 32'hFFF4_0006;
`endif

  typedef struct {
    int            k;
    int            base;
    bit            acc;
    bit            ident;
    int            aval;
    int            bval;
    int            mult;
    logic [CW-1:0] uni;
    bit            ovf;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  matmul_systolic_nxn_if #(.N(N), .DWIDTH(DW), .CWIDTH(CW), .AWIDTH(AW), .KWIDTH(KW)) bus ();

  matmul_systolic_nxn #(.N(N), .DWIDTH(DW), .CWIDTH(CW), .AWIDTH(AW), .KWIDTH(KW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // operand RAMs, one-cycle read latency
  logic [N*DW-1:0] a_mem [1<<AW];
  logic [N*DW-1:0] b_mem [1<<AW];
  always @(posedge clk) begin
    bus.a_data <= a_mem[bus.a_addr];
    bus.b_data <= b_mem[bus.b_addr];
  end

  // scoreboard
  int n_checks = 0;
  int n_err = 0;
  logic [N*CW-1:0] exp_q[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic load_job(input vec_t v);
    logic [N*DW-1:0] aw, bw;
    logic [AW-1:0] addr;
    for (int kk = 0; kk < v.k; kk++) begin
      addr = AW'(v.base + kk);
      for (int l = 0; l < N; l++) begin
        aw[l*DW +: DW] = v.ident ? DW'(l == kk) : DW'(v.aval);
        bw[l*DW +: DW] = v.ident ? DW'(N*kk + l + 1) : DW'(v.bval);
      end
      a_mem[addr] = aw;
      b_mem[addr] = bw;
    end
  endtask

  task automatic push_expected(input vec_t v);
    logic [N*CW-1:0] row;
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) begin
        row[j*CW +: CW] = v.ident ? CW'(v.mult * (N*r + j + 1)) : v.uni;
      end
      exp_q.push_back(row);
    end
  endtask

  // driver: issue a job, consume rows, return first-valid and done cycle offsets from the start edge
  task automatic run_job(input int k, input int base, input bit acc, input int stall_row,
                         input int stall_n, input bit poke, output int t_valid, output int t_done);
    int cyc, stalled, next_row;
    bit fin;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.k_len   = KW'(k);
    bus.a_base  = AW'(base);
    bus.b_base  = AW'(base);
    bus.acc_en  = acc;
    bus.c_ready = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    t_valid = -1; t_done = -1; cyc = 0; stalled = 0; next_row = 0; fin = 1'b0;
    while (!fin && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 2) begin
        bus.start  = 1'b1;
        bus.k_len  = KW'(1);
        bus.acc_en = 1'b0;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        t_done = cyc;
        fin = 1'b1;
      end else if (bus.c_valid) begin
        if (t_valid < 0) t_valid = cyc;
        if (next_row == stall_row && stalled < stall_n) begin
          bus.c_ready = 1'b0;
          stalled++;
          check("stall_row", 256'(bus.c_row), 256'(stall_row));
          if (exp_q.size() > 0) check("stall_data", 256'(bus.c_data), 256'(exp_q[0]));
        end else begin
          bus.c_ready = 1'b1;
          check("row_idx", 256'(bus.c_row), 256'(next_row));
          if (exp_q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL extra_row: got row %0d expected none", bus.c_row);
          end else begin
            check("row_data", 256'(bus.c_data), 256'(exp_q.pop_front()));
          end
          next_row++;
        end
      end
    end
    bus.c_ready = 1'b1;
    if (!fin) begin
      n_checks++; n_err++;
      $display("FAIL job_timeout: got no done after %0d cycles expected done", cyc);
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int t_valid, t_done;
    vec_t v;
    for (int i = 0; i < (1 << AW); i++) begin
      a_mem[i] = '0;
      b_mem[i] = '0;
    end
    vecs[0] = '{4, 510, 1'b0, 1'b1, 0, 0, 1, 32'd0, 1'b0};
    vecs[1] = '{4, 510, 1'b1, 1'b1, 0, 0, 2, 32'd0, 1'b0};
    vecs[2] = '{4, 20,  1'b0, 1'b1, 0, 0, 1, 32'd0, 1'b0};
    vecs[3] = '{1, 40,  1'b0, 1'b0, 3, 5, 0, 32'd15, 1'b0};
    vecs[4] = '{0, 60,  1'b0, 1'b0, 0, 0, 0, 32'd0, 1'b0};
    vecs[5] = '{2, 70,  1'b0, 1'b0, 2, 7, 0, 32'd28, 1'b0};
    vecs[6] = '{3, 80,  1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 0, OVF_K3, 1'b1};
    vecs[7] = '{3, 80,  1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 0, OVF_K3_ACC, 1'b1};

    reset = 1'b1;
    bus.start = 1'b0; bus.k_len = '0; bus.a_base = '0; bus.b_base = '0;
    bus.acc_en = 1'b0; bus.c_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_a_addr", 256'(bus.a_addr), 256'(0));
    check("rst_b_addr", 256'(bus.b_addr), 256'(0));
    check("rst_c_valid", 256'(bus.c_valid), 256'(0));
    check("rst_c_row", 256'(bus.c_row), 256'(0));
    check("rst_c_data", 256'(bus.c_data), 256'(0));
    check("rst_busy", 256'(bus.busy), 256'(0));
    check("rst_done", 256'(bus.done), 256'(0));
    check("rst_ovf", 256'(bus.ovf), 256'(0));

    for (int vi = 0; vi < 8; vi++) begin
      v = vecs[vi];
      load_job(v);
      push_expected(v);
      run_job(v.k, v.base, v.acc, -1, 0, 1'b0, t_valid, t_done);
      check($sformatf("v%0d_first_valid", vi), 256'(t_valid), 256'(v.k + 2*N + 1));
      check($sformatf("v%0d_done_cycle", vi), 256'(t_done), 256'(v.k + 3*N + 1));
      check($sformatf("v%0d_rows_left", vi), 256'(exp_q.size()), 256'(0));
      check($sformatf("v%0d_ovf", vi), 256'(bus.ovf), 256'(v.ovf));
      exp_q.delete();
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", vi), 256'(bus.done), 256'(0));
      check($sformatf("v%0d_idle", vi), 256'(bus.busy), 256'(0));
      if (v.k > 0) check($sformatf("v%0d_addr_hold", vi), 256'(bus.a_addr), 256'(AW'(v.base + v.k - 1)));
    end

    // reset in the middle of FEED, with ovf set and acc_en=1 so only reset can clear state
    v = '{4, 0, 1'b1, 1'b1, 0, 0, 1, 32'd0, 1'b0};
    load_job(v);
    @(negedge clk);
    bus.start = 1'b1; bus.k_len = KW'(4); bus.a_base = '0; bus.b_base = '0; bus.acc_en = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy_before", 256'(bus.busy), 256'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", 256'(bus.busy), 256'(0));
    check("mid_rst_ovf", 256'(bus.ovf), 256'(0));
    check("mid_rst_c_valid", 256'(bus.c_valid), 256'(0));
    check("mid_rst_a_addr", 256'(bus.a_addr), 256'(0));

    // fresh job after reset: acc_en=1 onto cleared accumulators, stall at row 1, start poked while busy
    push_expected(v);
    run_job(4, 0, 1'b1, 1, 5, 1'b1, t_valid, t_done);
    check("bp_first_valid", 256'(t_valid), 256'(4 + 2*N + 1));
    check("bp_done_cycle", 256'(t_done), 256'(4 + 3*N + 1 + 5));
    check("bp_rows_left", 256'(exp_q.size()), 256'(0));
    check("bp_ovf", 256'(bus.ovf), 256'(0));
    exp_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
